fib_scheduler: RTL and testbench
================================

# fib_scheduler

Shares one `fibonacci` engine among `NUM_REQ` requesters. Each job is a term index `n`; the result is the engine output plus the requester ID. The block grants requests round-robin and rejects out-of-range `n` without touching the engine. Before each job it clears the engine, launches it, waits for `done` under a watchdog, and returns one tagged response per accepted request. It sits between the host-side request ports and the single engine instance.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DW`, 16: data width of `n` and of the result.
- `WATCHDOG`, 64: maximum cycles spent in WAIT before the job is aborted.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `req_valid`  in  NUM_REQ  per-requester job request.
- `req_n`  in  NUM_REQ*DW  flattened indices; requester i uses bits [i*DW +: DW].
- `req_ready`  out  NUM_REQ  one-hot grant; at most one bit high.
- `resp_valid`  out  1  response available.
- `resp_ready`  in  1  consumer accepts response.
- `resp_id`  out  $clog2(NUM_REQ)  requester the response belongs to.
- `resp_data`  out  DW  result; 0 when `resp_err`=1.
- `resp_err`  out  1  the `n` was out of range, or the watchdog expired.
- `eng_reset`  out  1  engine reset; equals `reset` OR (state==CLR).
- `eng_start`  out  1  engine start, high only in LAUNCH.
- `eng_din`  out  DW  engine index, held from CLR until the job leaves WAIT.
- `eng_dout`  in  DW  engine result.
- `eng_done`  in  1  engine completion, registered in the engine.

## Operation
- State machine: IDLE, CLR, LAUNCH, WAIT, RESP.
- IDLE:
  - `req_ready` is the combinational round-robin winner among `req_valid`, searching from `rr_ptr`.
  - The handshake is `req_valid[i] & req_ready[i]`. On it, latch `id`=i and `n`=req_n[i], and set `rr_ptr` to (i+1) mod NUM_REQ.
  - If `n` < N_MIN (2) or `n` > N_MAX (31), go to RESP with err=1 and data=0. Otherwise go to CLR.
- CLR: one cycle; `eng_reset`=1. Then go to LAUNCH.
- LAUNCH: one cycle; `eng_start`=1. Clear the watchdog counter. Then go to WAIT.
- WAIT:
  - If `eng_done`=1, capture `eng_dout` into data, set err=0, and go to RESP.
  - Otherwise, if the watchdog counter reaches WATCHDOG-1, set err=1, data=0, and go to RESP.
  - Otherwise, increment the counter.
  - `eng_done` takes priority over the watchdog when both occur in the same cycle.
- RESP:
  - `resp_valid`=1, and `resp_id`, `resp_data`, `resp_err` are driven from the latched registers.
  - The response holds stable until `resp_valid & resp_ready`, then go to IDLE.
- `req_ready` is 0 in every state except IDLE. Requests are never dropped; they wait.
- `req_valid` may drop before grant without error.
- `eng_dout` and `eng_done` are ignored outside WAIT.
- Widths:
  - `rr_ptr` is $clog2(NUM_REQ) bits and wraps to 0 modulo NUM_REQ, including non-power-of-two values.
  - The watchdog counter is $clog2(WATCHDOG)+1 bits.
  - The range checks are unsigned compares on the full DW bits.

## Timing
- Reset values: state=IDLE, `rr_ptr`=0, `req_ready`=0, `resp_valid`=0, `resp_id`=0, `resp_data`=0, `resp_err`=0, `eng_start`=0, `eng_din`=0.
- `eng_reset`=1 for as long as `reset` is high.
- Reset asserted mid-job aborts the job with no response. The engine is reset in the same cycle.
- Grant to `eng_start`: 2 cycles (CLR, then LAUNCH).
- In-range job latency, grant edge to `resp_valid`: 3 + W cycles, where W is the number of WAIT cycles until `eng_done`.
- Out-of-range job: `resp_valid` is asserted on the cycle after the grant.
- Back-to-back jobs: RESP to IDLE costs one cycle, so the next grant comes at the earliest one cycle after the response handshake.
- `resp_ready` held high: RESP lasts exactly one cycle.

## Structure
- Package `fib_pkg`:
  - `fib_state_t` enum {IDLE, CLR, LAUNCH, WAIT, RESP} as logic [2:0].
  - Constants `N_MIN`=2 and `N_MAX`=31.
  - `FIB_DW`=16.
- Sub-module `rr_arbiter`:
  - Parameter NUM_REQ.
  - Inputs: `req`, `ptr`, `en`.
  - Output: one-hot `gnt`, combinational only.
  - The FSM, watchdog, and registers stay in `fib_scheduler`.

## Test plan
The bench uses a behavioural engine model that asserts `eng_done` `n` cycles after `eng_start` with `eng_dout`=F(n).
- Single request, req 0 with n=10 → one response: `resp_id`=0, `resp_data`=55, `resp_err`=0; `eng_start` pulses once, exactly 2 cycles after the grant.
- All four requesters valid, n=3, 4, 5, 6 → grants in order 0, 1, 2, 3; responses 2, 3, 5, 8. Then req 1 alone, after `rr_ptr`=0 → granted immediately.
- Req 2 with n=1, then n=40 → each gives `resp_err`=1, `resp_data`=0 one cycle after the grant; `eng_start` and `eng_reset` never pulse.
- Model never asserts done, n=20 → `resp_err`=1 after WATCHDOG=64 WAIT cycles.
- Same-cycle case: `eng_done` in the final watchdog cycle → `resp_err`=0 with the engine data.
- `resp_ready` low for 5 cycles with req 3 pending → response held stable and `req_ready` all zero; the grant to req 3 follows 1 cycle after the handshake.
- `reset` pulsed during WAIT → all outputs at reset values and `eng_reset`=1 during reset; no response is emitted; the next request completes normally.

Source files
------------

// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared types and constants for the fibonacci job scheduler
package fib_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CLR    = 3'd1,
      LAUNCH = 3'd2,
      WAIT   = 3'd3,
      RESP   = 3'd4
   } fib_state_t;

   localparam int N_MIN  = 2;
   localparam int N_MAX  = 31;
   localparam int FIB_DW = 16;

endpackage

// File: rtl/fib_scheduler_rr_arbiter.sv
// rtl/fib_scheduler_rr_arbiter.sv - combinational round-robin arbiter, search starts at ptr
module rr_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
   input  logic                       en,
   output logic [NUM_REQ-1:0]         gnt
);

   localparam int PW = $clog2(NUM_REQ);

   logic [PW-1:0] idx;
   logic          found;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         // modulo keeps the wrap correct for non-power-of-two requester counts
         idx = PW'((int'(ptr) + k) % NUM_REQ);
         if (en && !found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fib_scheduler.sv
// rtl/fib_scheduler.sv - shares one fibonacci engine among NUM_REQ requesters
module fib_scheduler
   import fib_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int DW       = FIB_DW,
   parameter int WATCHDOG = 64
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*DW-1:0]      req_n,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       resp_valid,
   input  logic                       resp_ready,
   output logic [$clog2(NUM_REQ)-1:0] resp_id,
   output logic [DW-1:0]              resp_data,
   output logic                       resp_err,
   output logic                       eng_reset,
   output logic                       eng_start,
   output logic [DW-1:0]              eng_din,
   input  logic [DW-1:0]              eng_dout,
   input  logic                       eng_done
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int WW = $clog2(WATCHDOG) + 1;

   fib_state_t    state_q;
   logic [IW-1:0] rr_ptr_q, rr_ptr_d;
   logic [IW-1:0] id_q;
   logic [DW-1:0] n_q;
   logic [DW-1:0] data_q;
   logic          err_q;
   logic [WW-1:0] wd_q;
   logic          resp_valid_q;
   logic          eng_start_q;

   logic [NUM_REQ-1:0] gnt;
   logic [IW-1:0]      gnt_id;
   logic [DW-1:0]      n_sel;
   logic               in_range;

   // grants are masked during reset so req_ready shows its reset value
   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req (req_valid),
      .ptr (rr_ptr_q),
      .en  ((state_q == IDLE) && !reset),
      .gnt (gnt)
   );

   always_comb begin
      gnt_id = '0;
      n_sel  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (gnt[k]) begin
            gnt_id = IW'(k);
            n_sel  = req_n[k*DW +: DW];
         end
      end
   end

   assign rr_ptr_d = (gnt_id == IW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
   assign in_range = (n_sel >= DW'(N_MIN)) && (n_sel <= DW'(N_MAX));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         id_q         <= '0;
         n_q          <= '0;
         data_q       <= '0;
         err_q        <= 1'b0;
         wd_q         <= '0;
         resp_valid_q <= 1'b0;
         eng_start_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (|(req_valid & gnt)) begin
                  id_q     <= gnt_id;
                  n_q      <= n_sel;
                  rr_ptr_q <= rr_ptr_d;
                  if (in_range) begin
                     state_q <= CLR;
                  end else begin
                     data_q       <= '0;
                     err_q        <= 1'b1;
                     resp_valid_q <= 1'b1;
                     state_q      <= RESP;
                  end
               end
            end
            CLR: begin
               eng_start_q <= 1'b1;
               state_q     <= LAUNCH;
            end
            LAUNCH: begin
               eng_start_q <= 1'b0;
               wd_q        <= '0;
               state_q     <= WAIT;
            end
            WAIT: begin
               // done wins over the watchdog when both land in the same cycle
               if (eng_done) begin
                  data_q       <= eng_dout;
                  err_q        <= 1'b0;
                  resp_valid_q <= 1'b1;
                  state_q      <= RESP;
               end else if (wd_q == WW'(WATCHDOG - 1)) begin
                  data_q       <= '0;
                  err_q        <= 1'b1;
                  resp_valid_q <= 1'b1;
                  state_q      <= RESP;
               end else begin
                  wd_q <= wd_q + 1'b1;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid_q <= 1'b0;
                  state_q      <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready  = gnt;
   assign resp_valid = resp_valid_q;
   assign resp_id    = id_q;
   assign resp_data  = data_q;
   assign resp_err   = err_q;
   assign eng_reset  = reset | (state_q == CLR);
   assign eng_start  = eng_start_q;
   assign eng_din    = n_q;

endmodule

// File: tb/tb_fib_scheduler.sv
// tb/tb_fib_scheduler.sv - directed bench with behavioural engine and response scoreboard
module tb_fib_scheduler;

   localparam int NR = 4;
   localparam int DW = 16;

   typedef struct packed {
      logic [1:0]  id;
      logic [15:0] data;
      logic        err;
   } exp_t;

   logic            clk = 1'b0;
   logic            reset;
   logic [NR-1:0]   req_valid;
   logic [NR*DW-1:0] req_n;
   logic [NR-1:0]   req_ready;
   logic            resp_valid;
   logic            resp_ready;
   logic [1:0]      resp_id;
   logic [DW-1:0]   resp_data;
   logic            resp_err;
   logic            eng_reset;
   logic            eng_start;
   logic [DW-1:0]   eng_din;
   logic [DW-1:0]   eng_dout = '0;
   logic            eng_done = 1'b0;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   last_grant = 0;
   int   last_start = 0;
   int   start_cnt = 0;
   int   erst_cnt = 0;
   exp_t sb[$];
   int   grant_q[$];

   int   dly_override = 0;
   bit   never_done = 1'b0;
   logic m_busy = 1'b0;
   int   m_cnt = 0;

   fib_scheduler #(.NUM_REQ(NR), .DW(DW), .WATCHDOG(64)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_n      (req_n),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_data  (resp_data),
      .resp_err   (resp_err),
      .eng_reset  (eng_reset),
      .eng_start  (eng_start),
      .eng_din    (eng_din),
      .eng_dout   (eng_dout),
      .eng_done   (eng_done)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] fib(input logic [15:0] n);
      logic [15:0] a = 16'd0;
      logic [15:0] b = 16'd1;
      logic [15:0] t;
      for (int i = 0; i < int'(n); i++) begin
         t = a + b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   // engine model: done is visible n cycles after the cycle in which start is seen
   always @(posedge clk) begin
      if (eng_reset) begin
         m_busy   <= 1'b0;
         eng_done <= 1'b0;
      end else begin
         eng_done <= 1'b0;
         if (eng_start) begin
            m_busy   <= 1'b1;
            m_cnt    <= ((dly_override > 0) ? dly_override : int'(eng_din)) - 1;
            eng_dout <= fib(eng_din);
         end else if (m_busy && !never_done) begin
            if (m_cnt <= 1) begin
               eng_done <= 1'b1;
               m_busy   <= 1'b0;
            end else begin
               m_cnt <= m_cnt - 1;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      logic [NR-1:0] hs;
      @(negedge clk);
      if (eng_start) begin
         start_cnt++;
         last_start = cyc;
      end
      if (eng_reset) erst_cnt++;
      hs = req_valid & req_ready;
      if (|hs) begin
         last_grant = cyc;
         for (int k = 0; k < NR; k++) if (hs[k]) grant_q.push_back(k);
      end
      @(posedge clk);
      #1;
      req_valid = req_valid & ~hs;
      cyc++;
   endtask

   task automatic request(input int id, input int n);
      req_n[id*DW +: DW] = 16'(n);
      req_valid[id]      = 1'b1;
   endtask

   task automatic expect_resp(input int id, input int data, input bit err);
      exp_t e;
      e.id   = 2'(id);
      e.data = 16'(data);
      e.err  = err;
      sb.push_back(e);
   endtask

   task automatic wait_resp(input string tag, input int budget, input int exp_lat);
      exp_t e;
      int   n = 0;
      while (!resp_valid && n < budget) begin
         tick();
         n++;
      end
      check({tag, "_valid"}, 32'(resp_valid), 32'd1);
      if (!resp_valid) return;
      if (sb.size() == 0) begin
         check({tag, "_unexpected"}, 32'(sb.size()), 32'd1);
      end else begin
         e = sb.pop_front();
         check({tag, "_id"}, 32'(resp_id), 32'(e.id));
         check({tag, "_data"}, 32'(resp_data), 32'(e.data));
         check({tag, "_err"}, 32'(resp_err), 32'(e.err));
         if (exp_lat >= 0) check({tag, "_lat"}, 32'(cyc - last_grant), 32'(exp_lat));
      end
      tick();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
   endtask

   initial begin
      int s0;
      int e0;
      reset      = 1'b1;
      req_valid  = '1;
      req_n      = '0;
      resp_ready = 1'b1;
      #1;
      check("rst_eng_reset", 32'(eng_reset), 32'd1);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_id", 32'(resp_id), 32'd0);
      check("rst_resp_data", 32'(resp_data), 32'd0);
      check("rst_resp_err", 32'(resp_err), 32'd0);
      check("rst_eng_start", 32'(eng_start), 32'd0);
      check("rst_eng_din", 32'(eng_din), 32'd0);
      req_valid = '0;
      reset     = 1'b0;
      tick();

      // single in-range job
      s0 = start_cnt;
      request(0, 10);
      expect_resp(0, 55, 1'b0);
      wait_resp("single", 40, 13);
      check("single_starts", 32'(start_cnt - s0), 32'd1);
      check("single_start_lat", 32'(last_start - last_grant), 32'd2);

      // four contenders from rr_ptr=0
      do_reset();
      grant_q.delete();
      for (int i = 0; i < NR; i++) begin
         request(i, 3 + i);
         expect_resp(i, int'(fib(16'(3 + i))), 1'b0);
      end
      for (int i = 0; i < NR; i++) wait_resp("rr", 40, 6 + i);
      check("rr_grants", 32'(grant_q.size()), 32'd4);
      for (int i = 0; i < NR && grant_q.size() > 0; i++)
         check("rr_order", 32'(grant_q.pop_front()), 32'(i));
      request(1, 2);
      #1;
      check("rr_req1_imm", 32'(req_ready), 32'b0010);
      expect_resp(1, 1, 1'b0);
      wait_resp("rr_req1", 40, 5);

      // out-of-range indices never touch the engine
      s0 = start_cnt;
      e0 = erst_cnt;
      request(2, 1);
      expect_resp(2, 0, 1'b1);
      wait_resp("oor_low", 10, 1);
      request(2, 40);
      expect_resp(2, 0, 1'b1);
      wait_resp("oor_high", 10, 1);
      check("oor_starts", 32'(start_cnt - s0), 32'd0);
      check("oor_eng_resets", 32'(erst_cnt - e0), 32'd0);

      // watchdog expiry
      never_done = 1'b1;
      request(0, 20);
      expect_resp(0, 0, 1'b1);
      wait_resp("wdog", 100, 67);
      never_done = 1'b0;

      // done in the final watchdog cycle wins
      dly_override = 64;
      request(1, 20);
      expect_resp(1, 6765, 1'b0);
      wait_resp("wdog_tie", 100, 67);
      dly_override = 0;

      // back-pressure with req 3 pending
      resp_ready = 1'b0;
      request(0, 5);
      expect_resp(0, 5, 1'b0);
      tick();
      request(3, 7);
      wait_resp("bp", 40, 8);
      repeat (4) begin
         check("bp_hold_valid", 32'(resp_valid), 32'd1);
         check("bp_hold_id", 32'(resp_id), 32'd0);
         check("bp_hold_data", 32'(resp_data), 32'd5);
         check("bp_req_ready", 32'(req_ready), 32'd0);
         tick();
      end
      resp_ready = 1'b1;
      tick();
      check("bp_next_grant", 32'(req_ready), 32'b1000);
      expect_resp(3, 13, 1'b0);
      wait_resp("bp_req3", 40, 10);

      // reset during WAIT aborts the job silently
      request(1, 15);
      repeat (5) tick();
      request(2, 12);
      reset = 1'b1;
      #1;
      check("mid_eng_reset", 32'(eng_reset), 32'd1);
      check("mid_resp_valid", 32'(resp_valid), 32'd0);
      check("mid_req_ready", 32'(req_ready), 32'd0);
      check("mid_eng_start", 32'(eng_start), 32'd0);
      check("mid_eng_din", 32'(eng_din), 32'd0);
      check("mid_resp_id", 32'(resp_id), 32'd0);
      check("mid_resp_data", 32'(resp_data), 32'd0);
      check("mid_resp_err", 32'(resp_err), 32'd0);
      @(posedge clk);
      #1;
      req_valid[1] = 1'b0;
      reset = 1'b0;
      expect_resp(2, 144, 1'b0);
      wait_resp("post_rst", 40, 15);

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
